// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined ARM-subset CPU: instruction field
// constants, the memory/writeback stage state type and its latency limits.
package cpu_pkg;

  // Instruction class field inst[27:25] value for single data transfers.
  localparam logic [2:0] INST_CLASS_LDST = 3'b010;

  // Load/store select bit: 1 = load, 0 = store.
  localparam int L_BIT = 20;

  // Program counter register index; a writeback here redirects fetch.
  localparam logic [3:0] PC_REG = 4'd15;

  // Longest supported memory read latency and the counter width that holds it.
  localparam int LOAD_LATENCY_MAX = 4;
  localparam int LAT_CNT_W        = 3;

  // Memory/writeback stage control states.
  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } mem_wb_state_e;

  // True when the instruction word is a single data transfer (LDR/STR).
  function automatic logic is_ldst(input logic [31:0] inst);
    return inst[27:25] == INST_CLASS_LDST;
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage. Executes word loads/stores against a
// synchronous data memory, drives the register-file write port, and raises
// a fetch redirect plus pipeline flush whenever R15 is written back.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int LOAD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  rd_addr_i,
  input  logic        do_write_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_r_not_w_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        pc_wb_o,
  output logic        flush_o
);

  // Reject unsupported latencies at elaboration time.
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > LOAD_LATENCY_MAX) begin : g_bad_latency
    $error("mem_wb_stage: LOAD_LATENCY out of range");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LOAD_LATENCY);

  mem_wb_state_e          state_reg, state_next;
  logic [LAT_CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]             ld_rd_reg;

  logic accept;
  logic inst_ldst;
  logic inst_load;
  logic do_alu_wb;
  logic do_store;
  logic do_load;
  logic load_done;

  // Only the class and L fields of the instruction matter to this stage.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_i[31:28], inst_i[24:21], inst_i[19:0]};

  // Execute must hold while a load is outstanding.
  assign stall_o = (state_reg == LOAD_WAIT);

  // Decode the accepted instruction into the three side-effect kinds.
  always_comb begin
    accept    = valid_i & (state_reg == IDLE);
    inst_ldst = is_ldst(inst_i);
    inst_load = inst_i[L_BIT];
    do_alu_wb = accept & do_write_i & ~inst_ldst;
    do_store  = accept & do_write_i & inst_ldst & ~inst_load;
    do_load   = accept & do_write_i & inst_ldst & inst_load;
    load_done = (state_reg == LOAD_WAIT) && (cnt_reg == LAT_CNT_W'(1));
  end

  // State register and latency down-counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: a load parks the stage until the counter reaches 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (do_load) begin
          state_next = LOAD_WAIT;
          cnt_next   = LAT_INIT;
        end
      end
      LOAD_WAIT: begin
        if (cnt_reg == LAT_CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - LAT_CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered memory and writeback outputs; strobes default low every cycle
  // so each event is a single-cycle pulse. The address register is only
  // reloaded on a new access, which keeps it stable across the load wait.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_r_not_w_o <= 1'b1;
      wb_en_o       <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      pc_wb_o       <= 1'b0;
      flush_o       <= 1'b0;
      ld_rd_reg     <= '0;
    end else begin
      wb_en_o       <= 1'b0;
      pc_wb_o       <= 1'b0;
      flush_o       <= 1'b0;
      mem_r_not_w_o <= 1'b1;
      if (do_alu_wb) begin
        wb_en_o   <= 1'b1;
        wb_addr_o <= rd_addr_i;
        wb_data_o <= alu_data_i;
        pc_wb_o   <= (rd_addr_i == PC_REG);
        flush_o   <= (rd_addr_i == PC_REG);
      end
      if (do_store) begin
        mem_addr_o    <= alu_data_i;
        mem_wdata_o   <= store_data_i;
        mem_r_not_w_o <= 1'b0;
      end
      if (do_load) begin
        mem_addr_o <= alu_data_i;
        ld_rd_reg  <= rd_addr_i;
      end
      if (load_done) begin
        wb_en_o   <= 1'b1;
        wb_addr_o <= ld_rd_reg;
        wb_data_o <= mem_rdata_i;
        pc_wb_o   <= (ld_rd_reg == PC_REG);
        flush_o   <= (ld_rd_reg == PC_REG);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: two instances (latency 3 and
// latency 1), each backed by a small synchronous data memory.
module tb_mem_wb_stage;

  localparam logic [31:0] OP_ALU = 32'hE080_0000;
  localparam logic [31:0] OP_STR = 32'hE580_0000;
  localparam logic [31:0] OP_LDR = 32'hE590_0000;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } st_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;

  logic        reset  [2];
  logic        valid  [2];
  logic [31:0] inst   [2];
  logic [31:0] alu    [2];
  logic [31:0] sdata  [2];
  logic [3:0]  rd     [2];
  logic        dw     [2];
  logic [31:0] rdata  [2];
  logic        stall  [2];
  logic [31:0] maddr  [2];
  logic [31:0] wdat   [2];
  logic        rnw    [2];
  logic        wbe    [2];
  logic [3:0]  wba    [2];
  logic [31:0] wbd    [2];
  logic        pcw    [2];
  logic        fl     [2];

  logic [31:0] dmem  [2][256];
  logic [31:0] model [2][256];

  wb_exp_t wbq0[$];
  wb_exp_t wbq1[$];
  st_exp_t sq0[$];
  st_exp_t sq1[$];

  function automatic int lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_wb_stage #(.LOAD_LATENCY(gi == 0 ? 3 : 1)) u_dut (
      .clk_i        (clk),
      .reset_i      (reset[gi]),
      .valid_i      (valid[gi]),
      .inst_i       (inst[gi]),
      .alu_data_i   (alu[gi]),
      .store_data_i (sdata[gi]),
      .rd_addr_i    (rd[gi]),
      .do_write_i   (dw[gi]),
      .mem_rdata_i  (rdata[gi]),
      .stall_o      (stall[gi]),
      .mem_addr_o   (maddr[gi]),
      .mem_wdata_o  (wdat[gi]),
      .mem_r_not_w_o(rnw[gi]),
      .wb_en_o      (wbe[gi]),
      .wb_addr_o    (wba[gi]),
      .wb_data_o    (wbd[gi]),
      .pc_wb_o      (pcw[gi]),
      .flush_o      (fl[gi])
    );

    assign rdata[gi] = dmem[gi][maddr[gi][9:2]];

    always @(posedge clk) begin
      if (!rnw[gi]) dmem[gi][maddr[gi][9:2]] <= wdat[gi];
    end

    // Output monitor: every writeback and memory write must match the head
    // of the corresponding scoreboard queue.
    always @(negedge clk) begin
      wb_exp_t we;
      st_exp_t se;
      bit got;
      if (wbe[gi]) begin
        got = 1'b0;
        if (gi == 0) begin
          if (wbq0.size() > 0) begin we = wbq0.pop_front(); got = 1'b1; end
        end else begin
          if (wbq1.size() > 0) begin we = wbq1.pop_front(); got = 1'b1; end
        end
        if (!got) begin
          check($sformatf("wb_unexpected[%0d]", gi), 32'(wbe[gi]), 32'd0);
        end else begin
          $display("dut%0d cycle %0d: writeback r%0d = 0x%08h", gi, cyc, wba[gi], wbd[gi]);
          check($sformatf("wb_cycle[%0d]", gi), cyc, we.cyc);
          check($sformatf("wb_addr[%0d]", gi), 32'(wba[gi]), 32'(we.addr));
          check($sformatf("wb_data[%0d]", gi), wbd[gi], we.data);
          check($sformatf("pc_wb[%0d]", gi), 32'(pcw[gi]), 32'(we.addr == 4'd15));
          check($sformatf("flush[%0d]", gi), 32'(fl[gi]), 32'(we.addr == 4'd15));
        end
      end else if (pcw[gi] || fl[gi]) begin
        check($sformatf("spurious_pc_flush[%0d]", gi), 32'({pcw[gi], fl[gi]}), 32'd0);
      end
      if (!rnw[gi]) begin
        got = 1'b0;
        if (gi == 0) begin
          if (sq0.size() > 0) begin se = sq0.pop_front(); got = 1'b1; end
        end else begin
          if (sq1.size() > 0) begin se = sq1.pop_front(); got = 1'b1; end
        end
        if (!got) begin
          check($sformatf("write_unexpected[%0d]", gi), 32'(rnw[gi]), 32'd1);
        end else begin
          $display("dut%0d cycle %0d: store [0x%08h] = 0x%08h", gi, cyc, maddr[gi], wdat[gi]);
          check($sformatf("st_cycle[%0d]", gi), cyc, se.cyc);
          check($sformatf("st_addr[%0d]", gi), maddr[gi], se.addr);
          check($sformatf("st_data[%0d]", gi), wdat[gi], se.data);
        end
      end
    end
  end

  // Present one instruction, hold it until accepted, and record what the
  // stage must produce. exp_stall >= 0 checks how many cycles it was held.
  task automatic issue(input int k, input logic [31:0] i_inst, input logic [31:0] i_alu,
                       input logic [31:0] i_sd, input logic [3:0] i_rd, input logic i_dw,
                       input bit expect_wb, input int exp_stall);
    int  n;
    int  c;
    bit  ok;
    bit  ldst;
    bit  load;
    wb_exp_t we;
    st_exp_t se;
    @(negedge clk);
    valid[k] = 1'b1;
    inst[k]  = i_inst;
    alu[k]   = i_alu;
    sdata[k] = i_sd;
    rd[k]    = i_rd;
    dw[k]    = i_dw;
    n  = 0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (!stall[k]) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (!ok) check($sformatf("accept_timeout[%0d]", k), 32'(stall[k]), 32'd0);
    c = cyc;
    $display("dut%0d cycle %0d: accept inst 0x%08h alu 0x%08h rd %0d dw %0d", k, c, i_inst, i_alu, i_rd, i_dw);
    if (exp_stall >= 0) check($sformatf("stall_len[%0d]", k), n, exp_stall);
    ldst = (i_inst[27:25] == 3'b010);
    load = i_inst[20];
    if (i_dw) begin
      if (!ldst) begin
        we = '{cyc: c + 1, addr: i_rd, data: i_alu};
        if (k == 0) wbq0.push_back(we); else wbq1.push_back(we);
      end else if (!load) begin
        se = '{cyc: c + 1, addr: i_alu, data: i_sd};
        if (k == 0) sq0.push_back(se); else sq1.push_back(se);
        model[k][i_alu[9:2]] = i_sd;
      end else if (expect_wb) begin
        we = '{cyc: c + 1 + lat(k), addr: i_rd, data: model[k][i_alu[9:2]]};
        if (k == 0) wbq0.push_back(we); else wbq1.push_back(we);
      end
    end
    @(posedge clk);
    #1 valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      valid[k] = 1'b0;
      inst[k]  = '0;
      alu[k]   = '0;
      sdata[k] = '0;
      rd[k]    = '0;
      dw[k]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rnw[%0d]", k), 32'(rnw[k]), 32'd1);
      check($sformatf("rst_wb_en[%0d]", k), 32'(wbe[k]), 32'd0);
      check($sformatf("rst_stall[%0d]", k), 32'(stall[k]), 32'd0);
      check($sformatf("rst_pc_flush[%0d]", k), 32'({pcw[k], fl[k]}), 32'd0);
      check($sformatf("rst_addr[%0d]", k), maddr[k], 32'd0);
      check($sformatf("rst_wb_data[%0d]", k), wbd[k], 32'd0);
      reset[k] = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      issue(k, OP_ALU, 32'h0000_00AA, 32'h0, 4'd3, 1'b1, 1'b1, 0);
      issue(k, OP_ALU, 32'h0000_0077, 32'h0, 4'd7, 1'b0, 1'b1, 0);
      issue(k, OP_ALU, 32'h1234_5678, 32'h0, 4'd4, 1'b1, 1'b1, 0);
      issue(k, OP_ALU, 32'h8765_4321, 32'h0, 4'd5, 1'b1, 1'b1, 0);
      issue(k, OP_STR, 32'h0000_0010, 32'hDEAD_BEEF, 4'd1, 1'b1, 1'b1, 0);
      issue(k, OP_STR, 32'h0000_0020, 32'h0000_0040, 4'd2, 1'b1, 1'b1, 0);
      issue(k, OP_STR, 32'h0000_0030, 32'hBAD0_BAD0, 4'd2, 1'b0, 1'b1, 0);
      issue(k, OP_LDR, 32'h0000_0010, 32'h0, 4'd5, 1'b1, 1'b1, 0);
      issue(k, OP_ALU, 32'h0000_0066, 32'h0, 4'd6, 1'b1, 1'b1, lat(k));
      issue(k, OP_LDR, 32'h0000_0020, 32'h0, 4'd15, 1'b1, 1'b1, 0);
      issue(k, OP_ALU, 32'h0000_0100, 32'h0, 4'd15, 1'b1, 1'b1, lat(k));
      issue(k, OP_LDR, 32'h0000_0010, 32'h0, 4'd9, 1'b0, 1'b1, 0);
      issue(k, OP_ALU, 32'h0000_0099, 32'h0, 4'd9, 1'b1, 1'b1, 0);
      repeat (6) @(negedge clk);
    end

    // Reset in the middle of a latency-3 load abandons it.
    issue(0, OP_LDR, 32'h0000_0010, 32'h0, 4'd8, 1'b1, 1'b0, 0);
    @(negedge clk);
    check("midload_stall", 32'(stall[0]), 32'd1);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    check("postrst_stall", 32'(stall[0]), 32'd0);
    check("postrst_wb_en", 32'(wbe[0]), 32'd0);
    check("postrst_rnw", 32'(rnw[0]), 32'd1);
    repeat (8) @(negedge clk);
    issue(0, OP_ALU, 32'h0000_0055, 32'h0, 4'd2, 1'b1, 1'b1, 0);

    repeat (8) @(negedge clk);
    check("wbq0_drained", 32'(wbq0.size()), 32'd0);
    check("wbq1_drained", 32'(wbq1.size()), 32'd0);
    check("sq0_drained", 32'(sq0.size()), 32'd0);
    check("sq1_drained", 32'(sq1.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
